// File: rtl/apb_i2c_csr_bank_if.sv
// APB3 slave-side bus bundle for the I2C CSR bank.
// Signal names keep the slave's port view: *_i are driven by the master, *_o by the slave.
interface apb_i2c_csr_bank_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic                  pwrite_i;
    logic                  psel_i;
    logic                  penable_i;
    logic [DATA_WIDTH-1:0] pwdata_i;
    logic [DATA_WIDTH-1:0] prdata_o;
    logic                  pready_o;
    logic                  pslverr_o;

    modport master (
        output paddr_i, pwrite_i, psel_i, penable_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  paddr_i, pwrite_i, psel_i, penable_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_i2c_csr_bank.sv
// APB3 control/status register bank for the I2C master core: wait-stated access, PSLVERR,
// TX push / RX pop strobes and a maskable interrupt with write-1-to-clear status.
module apb_i2c_csr_bank #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned WAIT_STATES  = 0,
    parameter logic [7:0]  PRESCALE_RST = 8'd0
) (
    input  logic              pclk_i,
    input  logic              preset_i,
    apb_i2c_csr_bank_if.slave apb,
    input  logic [7:0]        status_i,
    input  logic [7:0]        rx_data_i,
    input  logic [3:0]        evt_i,
    input  logic              start_done_i,
    input  logic              reset_done_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_push_o,
    output logic              rx_pop_o,
    output logic [7:0]        slave_addr_o,
    output logic [7:0]        cmd_o,
    output logic [7:0]        prescale_o,
    output logic              irq_o
);
    localparam logic [2:0] IdxTx       = 3'd0;
    localparam logic [2:0] IdxRx       = 3'd1;
    localparam logic [2:0] IdxStatus   = 3'd2;
    localparam logic [2:0] IdxSaddr    = 3'd3;
    localparam logic [2:0] IdxCmd      = 3'd4;
    localparam logic [2:0] IdxPrescale = 3'd5;
    localparam logic [2:0] IdxIrqEn    = 3'd6;
    localparam logic [2:0] IdxIrqStat  = 3'd7;

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e                state_q, state_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [7:0]            saddr_q, saddr_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [7:0]            prescale_q, prescale_d;
    logic [3:0]            irq_en_q, irq_en_d;
    logic [3:0]            irq_stat_q, irq_stat_d;
    logic                  tx_push_q, tx_push_d;
    logic                  rx_pop_q, rx_pop_d;
    logic                  irq_q, irq_d;

    logic [2:0] idx;
    logic       addr_oob;
    logic       setup;
    logic       ready;
    logic       done;
    logic       err;
    logic       wr_ok;
    logic       rd_ok;
    logic [7:0] wbyte;
    logic [7:0] rd_val;

    assign idx      = apb.paddr_i[2:0];
    assign addr_oob = apb.paddr_i > ADDR_WIDTH'(7);
    assign setup    = (state_q == StIdle) & apb.psel_i & ~apb.penable_i;
    assign ready    = (state_q == StAccess) & (wcnt_q == 4'd0);
    assign done     = ready & apb.psel_i & apb.penable_i;
    assign err      = addr_oob | (apb.pwrite_i & ((idx == IdxRx) | (idx == IdxStatus) |
                                                  ((idx == IdxTx) & status_i[0])));
    assign wr_ok    = done & apb.pwrite_i & ~err;
    assign rd_ok    = done & ~apb.pwrite_i & ~err;
    assign wbyte    = apb.pwdata_i[7:0];

    if (DATA_WIDTH > 8) begin : g_unused_wdata
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^apb.pwdata_i[DATA_WIDTH-1:8];
    end

    always_comb begin
        rd_val = 8'h00;
        if (!addr_oob) begin
            case (idx)
                IdxTx:       rd_val = tx_data_q;
                IdxRx:       rd_val = rx_data_i;
                IdxStatus:   rd_val = status_i;
                IdxSaddr:    rd_val = saddr_q;
                IdxCmd:      rd_val = cmd_q;
                IdxPrescale: rd_val = prescale_q;
                IdxIrqEn:    rd_val = {4'h0, irq_en_q};
                IdxIrqStat:  rd_val = {4'h0, irq_stat_q};
                default:     rd_val = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            StIdle: begin
                if (setup) begin
                    state_d = StAccess;
                    wcnt_d  = 4'(WAIT_STATES);
                end
            end
            StAccess: begin
                // Deselect mid-access abandons the transfer; no register is touched.
                if (!apb.psel_i || done) begin
                    state_d = StIdle;
                end else if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        prdata_d   = prdata_q;
        tx_data_d  = tx_data_q;
        saddr_d    = saddr_q;
        cmd_d      = cmd_q;
        prescale_d = prescale_q;
        irq_en_d   = irq_en_q;
        irq_stat_d = irq_stat_q;
        tx_push_d  = 1'b0;
        rx_pop_d   = rd_ok & (idx == IdxRx);
        irq_d      = |(irq_stat_q & irq_en_q);

        if (setup && !apb.pwrite_i) begin
            prdata_d = DATA_WIDTH'(rd_val);
        end

        // Core-side clears first so a same-edge APB write to CMD overrides them.
        if (start_done_i) cmd_d[6] = 1'b0;
        if (reset_done_i) cmd_d[7] = 1'b0;

        if (wr_ok) begin
            case (idx)
                IdxTx: begin
                    tx_data_d = wbyte;
                    tx_push_d = 1'b1;
                end
                IdxSaddr:    saddr_d    = wbyte;
                IdxCmd:      cmd_d      = wbyte;
                IdxPrescale: prescale_d = wbyte;
                IdxIrqEn:    irq_en_d   = wbyte[3:0];
                IdxIrqStat:  irq_stat_d = irq_stat_q & ~wbyte[3:0];
                default: ;
            endcase
        end

        irq_stat_d = irq_stat_d | evt_i;
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q    <= StIdle;
            wcnt_q     <= 4'd0;
            prdata_q   <= '0;
            tx_data_q  <= 8'h00;
            saddr_q    <= 8'h00;
            cmd_q      <= 8'h00;
            prescale_q <= PRESCALE_RST;
            irq_en_q   <= 4'h0;
            irq_stat_q <= 4'h0;
            tx_push_q  <= 1'b0;
            rx_pop_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            prdata_q   <= prdata_d;
            tx_data_q  <= tx_data_d;
            saddr_q    <= saddr_d;
            cmd_q      <= cmd_d;
            prescale_q <= prescale_d;
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            tx_push_q  <= tx_push_d;
            rx_pop_q   <= rx_pop_d;
            irq_q      <= irq_d;
        end
    end

    assign apb.prdata_o  = prdata_q;
    assign apb.pready_o  = ready;
    assign apb.pslverr_o = ready & err;
    assign tx_data_o     = tx_data_q;
    assign tx_push_o     = tx_push_q;
    assign rx_pop_o      = rx_pop_q;
    assign slave_addr_o  = saddr_q;
    assign cmd_o         = cmd_q;
    assign prescale_o    = prescale_q;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_apb_i2c_csr_bank.sv
// Self-checking bench for apb_i2c_csr_bank: one zero-wait instance, one two-wait instance,
// APB expectations queued per transfer and compared when the transfer completes.
module tb_apb_i2c_csr_bank;
    localparam int DW = 32;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          tgt;  // 1 selects the two-wait instance
    logic [AW-1:0] paddr;
    logic          pwrite, psel, penable;
    logic [DW-1:0] pwdata;
    logic [7:0]    status, rx_data;
    logic [3:0]    evt;
    logic          start_done, reset_done;

    apb_i2c_csr_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    apb_i2c_csr_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    assign bus0.paddr_i   = paddr;
    assign bus0.pwrite_i  = pwrite;
    assign bus0.pwdata_i  = pwdata;
    assign bus0.penable_i = penable;
    assign bus0.psel_i    = psel & ~tgt;
    assign bus2.paddr_i   = paddr;
    assign bus2.pwrite_i  = pwrite;
    assign bus2.pwdata_i  = pwdata;
    assign bus2.penable_i = penable;
    assign bus2.psel_i    = psel & tgt;

    logic          pready_m, pslverr_m;
    logic [DW-1:0] prdata_m;
    assign pready_m  = tgt ? bus2.pready_o  : bus0.pready_o;
    assign pslverr_m = tgt ? bus2.pslverr_o : bus0.pslverr_o;
    assign prdata_m  = tgt ? bus2.prdata_o  : bus0.prdata_o;

    logic [7:0] tx_data, saddr, cmd, prescale;
    logic       tx_push, rx_pop, irq;
    logic [7:0] tx_data0, saddr0, cmd0, prescale0;
    logic       tx_push0, rx_pop0, irq0;

    apb_i2c_csr_bank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(0), .PRESCALE_RST(8'h00)
    ) u_dut0 (
        .pclk_i(clk), .preset_i(rst), .apb(bus0),
        .status_i(status), .rx_data_i(rx_data), .evt_i(evt),
        .start_done_i(start_done), .reset_done_i(reset_done),
        .tx_data_o(tx_data0), .tx_push_o(tx_push0), .rx_pop_o(rx_pop0),
        .slave_addr_o(saddr0), .cmd_o(cmd0), .prescale_o(prescale0), .irq_o(irq0)
    );

    apb_i2c_csr_bank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(2), .PRESCALE_RST(8'h37)
    ) u_dut2 (
        .pclk_i(clk), .preset_i(rst), .apb(bus2),
        .status_i(status), .rx_data_i(rx_data), .evt_i(evt),
        .start_done_i(start_done), .reset_done_i(reset_done),
        .tx_data_o(tx_data), .tx_push_o(tx_push), .rx_pop_o(rx_pop),
        .slave_addr_o(saddr), .cmd_o(cmd), .prescale_o(prescale), .irq_o(irq)
    );

    typedef struct {
        string         name;
        logic [DW-1:0] rdata;
        logic          chk_rdata;
        logic          err;
        int            waits;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Drives one APB transfer; at_done = {reset_done, start_done, evt} asserted on the completion edge.
    task automatic apb_xfer(input logic t, input logic [AW-1:0] a, input logic w,
                            input logic [DW-1:0] wd, input logic [5:0] at_done,
                            output logic [DW-1:0] rd, output logic er, output int waits);
        @(negedge clk);
        tgt = t; paddr = a; pwrite = w; pwdata = wd; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        waits   = 0;
        while (pready_m !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (pready_m !== 1'b1) waits = -1;
        er = pslverr_m;
        {reset_done, start_done, evt} = at_done;
        @(posedge clk);
        #1;
        {reset_done, start_done, evt} = '0;
        rd   = prdata_m;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus2.prdata_o, bus2.pready_o, bus2.pslverr_o, tx_push, rx_pop, irq} !== '0) begin
            $display("FAIL reset_bus: prdata=%h pready=%b pslverr=%b push=%b pop=%b irq=%b, required all 0",
                     bus2.prdata_o, bus2.pready_o, bus2.pslverr_o, tx_push, rx_pop, irq);
        end else n_pass++;
        n_checks++;
        if ({tx_data, saddr, cmd, prescale} !== {8'h00, 8'h00, 8'h00, 8'h37}) begin
            $display("FAIL reset_regs: tx=%h saddr=%h cmd=%h pre=%h, required 00 00 00 37",
                     tx_data, saddr, cmd, prescale);
        end else n_pass++;
        n_checks++;
        if ({prescale0, saddr0} !== 16'h0000) begin
            $display("FAIL reset_dut0: pre=%h saddr=%h, required 00 00", prescale0, saddr0);
        end else n_pass++;
    endtask

    task automatic test_zero_wait();
        logic [DW-1:0] rd;
        logic          er;
        int            wt;
        exp_t          e;
        sb_q.push_back('{"zw_write_saddr", '0, 1'b0, 1'b0, 0});
        apb_xfer(1'b0, 8'd3, 1'b1, 32'h5A, 6'h00, rd, er, wt);
        e = sb_q.pop_front();
        n_checks++;
        if (er !== e.err || wt != e.waits) begin
            $display("FAIL %s: err=%b waits=%0d, required err=%b waits=%0d", e.name, er, wt, e.err, e.waits);
        end else n_pass++;
        n_checks++;
        if (saddr0 !== 8'h5A) $display("FAIL zw_saddr_out: got %h, required 5a", saddr0);
        else n_pass++;
        sb_q.push_back('{"zw_read_saddr", 32'h5A, 1'b1, 1'b0, 0});
        apb_xfer(1'b0, 8'd3, 1'b0, '0, 6'h00, rd, er, wt);
        e = sb_q.pop_front();
        n_checks++;
        if (er !== e.err || wt != e.waits || rd !== e.rdata) begin
            $display("FAIL %s: rdata=%h err=%b waits=%0d, required %h %b %0d",
                     e.name, rd, er, wt, e.rdata, e.err, e.waits);
        end else n_pass++;
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] rd;
        logic          er;
        int            wt;
        exp_t          e;
        sb_q.push_back('{"ws_read_prescale", 32'h37, 1'b1, 1'b0, 2});
        apb_xfer(1'b1, 8'd5, 1'b0, '0, 6'h00, rd, er, wt);
        e = sb_q.pop_front();
        n_checks++;
        if (er !== e.err || wt != e.waits || rd !== e.rdata) begin
            $display("FAIL %s: rdata=%h err=%b waits=%0d, required %h %b %0d",
                     e.name, rd, er, wt, e.rdata, e.err, e.waits);
        end else n_pass++;
    endtask

    task automatic test_tx();
        logic [DW-1:0] rd;
        logic          er;
        int            wt;
        int            pushes;
        exp_t          e;
        status = 8'h02;
        sb_q.push_back('{"tx_write_ok", '0, 1'b0, 1'b0, 2});
        apb_xfer(1'b1, 8'd0, 1'b1, 32'hA5, 6'h00, rd, er, wt);
        n_checks++;
        if (tx_data !== 8'hA5) $display("FAIL tx_data: got %h, required a5", tx_data);
        else n_pass++;
        pushes = 0;
        for (int i = 0; i < 4; i++) begin
            if (tx_push === 1'b1) pushes++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (pushes != 1) $display("FAIL tx_push_count: got %0d, required 1", pushes);
        else n_pass++;
        e = sb_q.pop_front();
        n_checks++;
        if (er !== e.err || wt != e.waits) begin
            $display("FAIL %s: err=%b waits=%0d, required err=%b waits=%0d", e.name, er, wt, e.err, e.waits);
        end else n_pass++;

        status = 8'h01;
        sb_q.push_back('{"tx_write_full", '0, 1'b0, 1'b1, 2});
        apb_xfer(1'b1, 8'd0, 1'b1, 32'h11, 6'h00, rd, er, wt);
        pushes = 0;
        for (int i = 0; i < 4; i++) begin
            if (tx_push === 1'b1) pushes++;
            @(posedge clk);
            #1;
        end
        e = sb_q.pop_front();
        n_checks++;
        if (er !== e.err || wt != e.waits || pushes != 0 || tx_data !== 8'hA5) begin
            $display("FAIL %s: err=%b waits=%0d pushes=%0d tx=%h, required err=1 waits=2 pushes=0 tx=a5",
                     e.name, er, wt, pushes, tx_data);
        end else n_pass++;

        sb_q.push_back('{"tx_readback", 32'hA5, 1'b1, 1'b0, 2});
        apb_xfer(1'b1, 8'd0, 1'b0, '0, 6'h00, rd, er, wt);
        e = sb_q.pop_front();
        n_checks++;
        if (er !== e.err || wt != e.waits || rd !== e.rdata) begin
            $display("FAIL %s: rdata=%h err=%b waits=%0d, required %h %b %0d",
                     e.name, rd, er, wt, e.rdata, e.err, e.waits);
        end else n_pass++;
        status = 8'h00;
    endtask

    task automatic test_rx();
        logic [DW-1:0] rd[3];
        logic          er[3];
        int            wt[3];
        int            pops[3];
        exp_t          e;
        logic [AW-1:0] addrs[3] = '{8'd1, 8'd9, 8'd2};
        logic          wrs[3]   = '{1'b0, 1'b0, 1'b1};
        rx_data = 8'h3C;
        sb_q.push_back('{"rx_read", 32'h3C, 1'b1, 1'b0, 2});
        sb_q.push_back('{"rx_read_oob", 32'h0, 1'b1, 1'b1, 2});
        sb_q.push_back('{"write_status_ro", '0, 1'b0, 1'b1, 2});
        for (int k = 0; k < 3; k++) begin
            apb_xfer(1'b1, addrs[k], wrs[k], 32'hFF, 6'h00, rd[k], er[k], wt[k]);
            pops[k] = 0;
            for (int i = 0; i < 4; i++) begin
                if (rx_pop === 1'b1) pops[k]++;
                @(posedge clk);
                #1;
            end
        end
        for (int k = 0; k < 3; k++) begin
            e = sb_q.pop_front();
            n_checks++;
            if (er[k] !== e.err || wt[k] != e.waits || (e.chk_rdata && rd[k] !== e.rdata) ||
                pops[k] != (k == 0 ? 1 : 0)) begin
                $display("FAIL %s: rdata=%h err=%b waits=%0d pops=%0d, required %h %b %0d %0d",
                         e.name, rd[k], er[k], wt[k], pops[k], e.rdata, e.err, e.waits, k == 0 ? 1 : 0);
            end else n_pass++;
        end
    endtask

    task automatic test_irq();
        logic [DW-1:0] rd;
        logic          er;
        int            wt;
        exp_t          e;
        apb_xfer(1'b1, 8'd6, 1'b1, 32'h2, 6'h00, rd, er, wt);
        @(negedge clk);
        evt = 4'b0001;
        @(negedge clk);
        evt = 4'b0000;
        repeat (2) @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_masked: got %b, required 0", irq);
        else n_pass++;
        @(negedge clk);
        evt = 4'b0010;
        @(posedge clk);
        #1;
        evt = 4'b0000;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_latency: got %b on set edge, required 0", irq);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (irq !== 1'b1) $display("FAIL irq_set: got %b, required 1", irq);
        else n_pass++;

        sb_q.push_back('{"irq_stat_read", 32'h03, 1'b1, 1'b0, 2});
        apb_xfer(1'b1, 8'd7, 1'b0, '0, 6'h00, rd, er, wt);
        e = sb_q.pop_front();
        n_checks++;
        if (er !== e.err || wt != e.waits || rd !== e.rdata) begin
            $display("FAIL %s: rdata=%h err=%b waits=%0d, required %h %b %0d",
                     e.name, rd, er, wt, e.rdata, e.err, e.waits);
        end else n_pass++;

        apb_xfer(1'b1, 8'd7, 1'b1, 32'h2, 6'h00, rd, er, wt);
        @(posedge clk);
        #1;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_w1c: got %b, required 0", irq);
        else n_pass++;

        // W1C of bit 1 on the same edge as its event: the set must win.
        apb_xfer(1'b1, 8'd7, 1'b1, 32'h2, 6'b000010, rd, er, wt);
        sb_q.push_back('{"irq_set_wins", 32'h03, 1'b1, 1'b0, 2});
        apb_xfer(1'b1, 8'd7, 1'b0, '0, 6'h00, rd, er, wt);
        e = sb_q.pop_front();
        n_checks++;
        if (er !== e.err || wt != e.waits || rd !== e.rdata || irq !== 1'b1) begin
            $display("FAIL %s: rdata=%h irq=%b, required %h irq=1", e.name, rd, irq, e.rdata);
        end else n_pass++;
        apb_xfer(1'b1, 8'd7, 1'b1, 32'hF, 6'h00, rd, er, wt);
    endtask

    task automatic test_cmd();
        logic [DW-1:0] rd;
        logic          er;
        int            wt;
        exp_t          e;
        apb_xfer(1'b1, 8'd4, 1'b1, 32'hC0, 6'h00, rd, er, wt);
        n_checks++;
        if (cmd !== 8'hC0) $display("FAIL cmd_write: got %h, required c0", cmd);
        else n_pass++;
        @(negedge clk);
        start_done = 1'b1;
        @(negedge clk);
        start_done = 1'b0;
        n_checks++;
        if (cmd !== 8'h80) $display("FAIL cmd_start_done: got %h, required 80", cmd);
        else n_pass++;
        @(negedge clk);
        reset_done = 1'b1;
        @(negedge clk);
        reset_done = 1'b0;
        n_checks++;
        if (cmd !== 8'h00) $display("FAIL cmd_reset_done: got %h, required 00", cmd);
        else n_pass++;
        apb_xfer(1'b1, 8'd4, 1'b1, 32'hC0, 6'b110000, rd, er, wt);
        sb_q.push_back('{"cmd_write_wins", 32'hC0, 1'b1, 1'b0, 2});
        apb_xfer(1'b1, 8'd4, 1'b0, '0, 6'h00, rd, er, wt);
        e = sb_q.pop_front();
        n_checks++;
        if (er !== e.err || wt != e.waits || rd !== e.rdata) begin
            $display("FAIL %s: rdata=%h err=%b waits=%0d, required %h %b %0d",
                     e.name, rd, er, wt, e.rdata, e.err, e.waits);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs[6] = '{8'd3, 8'd3, 8'd5, 8'd5, 8'd8, 8'd6};
        logic          wrs[6]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [DW-1:0] wds[6]   = '{32'hFFFF_FF22, 32'h0, 32'h99, 32'h0, 32'h0, 32'h0};
        logic [DW-1:0] rd[6];
        logic          er[6];
        int            wt[6];
        exp_t          e;
        sb_q.push_back('{"b2b_wr_saddr", '0, 1'b0, 1'b0, 2});
        sb_q.push_back('{"b2b_rd_saddr", 32'h22, 1'b1, 1'b0, 2});
        sb_q.push_back('{"b2b_wr_pre", '0, 1'b0, 1'b0, 2});
        sb_q.push_back('{"b2b_rd_pre", 32'h99, 1'b1, 1'b0, 2});
        sb_q.push_back('{"b2b_rd_oob", 32'h0, 1'b1, 1'b1, 2});
        sb_q.push_back('{"b2b_rd_irq_en", 32'h02, 1'b1, 1'b0, 2});
        for (int k = 0; k < 6; k++) begin
            apb_xfer(1'b1, addrs[k], wrs[k], wds[k], 6'h00, rd[k], er[k], wt[k]);
        end
        for (int k = 0; k < 6; k++) begin
            e = sb_q.pop_front();
            n_checks++;
            if (er[k] !== e.err || wt[k] != e.waits || (e.chk_rdata && rd[k] !== e.rdata)) begin
                $display("FAIL %s: rdata=%h err=%b waits=%0d, required %h %b %0d",
                         e.name, rd[k], er[k], wt[k], e.rdata, e.err, e.waits);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int pushes;
        @(negedge clk);
        evt = 4'b0010;
        @(negedge clk);
        evt = 4'b0000;
        repeat (2) @(negedge clk);
        tgt = 1'b1; paddr = 8'd0; pwrite = 1'b1; pwdata = 32'h77; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        n_checks++;
        if ({bus2.prdata_o, bus2.pready_o, bus2.pslverr_o, irq, saddr, cmd, prescale, tx_data} !==
            {32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h37, 8'h00}) begin
            $display("FAIL reset_mid_state: prdata=%h rdy=%b err=%b irq=%b saddr=%h cmd=%h pre=%h tx=%h",
                     bus2.prdata_o, bus2.pready_o, bus2.pslverr_o, irq, saddr, cmd, prescale, tx_data);
        end else n_pass++;
        pushes = 0;
        for (int i = 0; i < 4; i++) begin
            if (tx_push === 1'b1 || rx_pop === 1'b1) pushes++;
            @(negedge clk);
        end
        n_checks++;
        if (pushes != 0) $display("FAIL reset_mid_strobes: got %0d strobe cycles, required 0", pushes);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; tgt = 1'b1; paddr = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
        pwdata = '0; status = 8'h00; rx_data = 8'h00; evt = 4'h0;
        start_done = 1'b0; reset_done = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_tx();
        test_rx();
        test_irq();
        test_cmd();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: %0d left, required 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
